// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Handshake and writeback bundle between the instruction source,
//               the ALU operand stage and the ALU. The master modport is the
//               environment side (instruction source, ALU consumer, writeback).
//               The slave modport is the operand stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if;
  // Instruction input handshake
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  // Operand bundle output handshake
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in_1;
  logic [31:0] out_in_2;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_rd;
  // Writeback port
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // Dropped-instruction pulse
  logic        illegal;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_in_1, out_in_2, out_ctrl, out_rd, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_in_1, out_in_2, out_ctrl, out_rd, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Issue stage in front of the 32-bit ALU. Decodes RV32I OP and
//               OP-IMM instructions, reads a 32x32 register file with
//               write-through from the writeback port, and presents operands
//               and ALU control from a registered valid/ready slot.
//               Optional macro ALU_OPSTAGE_SCOREBOARD_EN adds a busy-bit
//               scoreboard that stalls issue on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  alu_operand_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_XOR = 3'b100;
  localparam logic [2:0] CTRL_SRA = 3'b101;
  localparam logic [2:0] CTRL_SRL = 3'b110;
  localparam logic [2:0] CTRL_SLL = 3'b111;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_sext;
  logic [31:0] shamt_zext;

  assign opcode     = bus.in_instr[6:0];
  assign rd         = bus.in_instr[11:7];
  assign funct3     = bus.in_instr[14:12];
  assign rs1        = bus.in_instr[19:15];
  assign rs2        = bus.in_instr[24:20];
  assign funct7     = bus.in_instr[31:25];
  assign imm_sext   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign shamt_zext = {27'd0, bus.in_instr[24:20]};

  // Decode results
  logic        dec_legal;
  logic        dec_is_op;
  logic [2:0]  dec_ctrl;
  logic [31:0] dec_imm;

  // Register file and read ports
  logic [31:0] regs_q [32];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Handshake
  logic        hazard;
  logic        in_ready_w;
  logic        accept;
  logic        load;

  // Output slot
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_in_1_q,  out_in_1_d;
  logic [31:0] out_in_2_q,  out_in_2_d;
  logic [2:0]  out_ctrl_q,  out_ctrl_d;
  logic [4:0]  out_rd_q,    out_rd_d;
  logic        illegal_q,   illegal_d;

  // Decode the offered instruction into legality, ALU op and immediate operand
  always_comb begin
    dec_legal = 1'b0;
    dec_is_op = 1'b0;
    dec_ctrl  = CTRL_ADD;
    dec_imm   = '0;
    case (opcode)
      OPC_OP: begin
        dec_is_op = 1'b1;
        case (funct3)
          3'b000: begin
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_ctrl  = (funct7 == F7_ALT) ? CTRL_SUB : CTRL_ADD;
          end
          3'b111: begin
            dec_legal = (funct7 == F7_BASE);
            dec_ctrl  = CTRL_AND;
          end
          3'b110: begin
            dec_legal = (funct7 == F7_BASE);
            dec_ctrl  = CTRL_OR;
          end
          3'b100: begin
            dec_legal = (funct7 == F7_BASE);
            dec_ctrl  = CTRL_XOR;
          end
          3'b001: begin
            dec_legal = (funct7 == F7_BASE);
            dec_ctrl  = CTRL_SLL;
          end
          3'b101: begin
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_ctrl  = (funct7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        // For OP-IMM the funct7 field is imm[11:5]; it only matters for shifts
        case (funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_ADD;
            dec_imm   = imm_sext;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_AND;
            dec_imm   = imm_sext;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_OR;
            dec_imm   = imm_sext;
          end
          3'b100: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_XOR;
            dec_imm   = imm_sext;
          end
          3'b001: begin
            dec_legal = (funct7 == F7_BASE);
            dec_ctrl  = CTRL_SLL;
            dec_imm   = shamt_zext;
          end
          3'b101: begin
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_ctrl  = (funct7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
            dec_imm   = shamt_zext;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Register reads with same-cycle writeback forwarding; x0 always reads zero
  always_comb begin
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
    if (bus.wb_en && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
    if (bus.wb_en && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

`ifdef ALU_OPSTAGE_SCOREBOARD_EN
  // Busy bit per architectural register x1..x31
  logic [31:1] busy_q, busy_d;
  logic [31:0] wb_clr;
  logic [31:0] busy_eff;
  logic [31:0] busy_set;

  // Busy view with this cycle's writeback already retired, and the stall check
  always_comb begin
    wb_clr = '0;
    if (bus.wb_en) wb_clr[bus.wb_rd] = 1'b1;
    busy_eff = {busy_q, 1'b0} & ~wb_clr;
    hazard   = dec_legal &&
               (busy_eff[rs1] || (dec_is_op && busy_eff[rs2]) || busy_eff[rd]);
  end

  // Next busy vector: clear on writeback, then set on issue so set wins
  always_comb begin
    busy_set = busy_eff;
    if (load && (rd != 5'd0)) busy_set[rd] = 1'b1;
    busy_d = busy_set[31:1];
  end

  // Busy register
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  assign hazard = 1'b0;
`endif

  assign in_ready_w = !rst && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept     = bus.in_valid && in_ready_w;
  assign load       = accept && dec_legal;

  // Register file: writeback lands whenever strobed, x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q[0] <= '0;
      for (int i = 1; i < 32; i++) regs_q[i] <= REG_RESET_VAL;
    end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Output slot next state: load replaces, consume empties, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_in_1_d  = out_in_1_q;
    out_in_2_d  = out_in_2_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd_d    = out_rd_q;
    illegal_d   = accept && !dec_legal;
    if (load) begin
      out_valid_d = 1'b1;
      out_in_1_d  = rs1_val;
      out_in_2_d  = dec_is_op ? rs2_val : dec_imm;
      out_ctrl_d  = dec_ctrl;
      out_rd_d    = rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_in_1_q  <= '0;
      out_in_2_q  <= '0;
      out_ctrl_q  <= CTRL_ADD;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_in_1_q  <= out_in_1_d;
      out_in_2_q  <= out_in_2_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_in_1  = out_in_1_q;
  assign bus.out_in_2  = out_in_2_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage. A behavioural model
//               (register array, busy flags, single output slot) predicts
//               in_ready, the operand bundle and the illegal pulse each cycle.
//               Scoreboard checks are built when ALU_OPSTAGE_SCOREBOARD_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam logic [31:0] RST_VAL = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.REG_RESET_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] ref_regs [32];
  bit          ref_busy [32];
  bit          m_valid;
  logic [31:0] m_in1, m_in2;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd;
  bit          m_illegal;
  bit          m_ready;
  logic        obs_ready;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction

  // Instruction semantics as a table of mnemonics
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs2v,
                                     output bit legal, output bit uses2,
                                     output logic [31:0] b, output logic [2:0] ctl);
    logic [6:0] f7 = ins[31:25];
    logic [2:0] f3 = ins[14:12];
    legal = 0; uses2 = 0; b = '0; ctl = 3'd0;
    if (ins[6:0] == 7'b0110011) begin
      uses2 = 1; b = rs2v;
      if (f7 == 7'h00) begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        case (f3)
          3'b000: ctl = 3'd0;   // add
          3'b001: ctl = 3'd7;   // sll
          3'b100: ctl = 3'd4;   // xor
          3'b101: ctl = 3'd6;   // srl
          3'b110: ctl = 3'd3;   // or
          3'b111: ctl = 3'd2;   // and
          default: ctl = 3'd0;
        endcase
      end else if (f7 == 7'h20) begin
        legal = (f3 == 3'b000) || (f3 == 3'b101);
        ctl   = (f3 == 3'b000) ? 3'd1 : 3'd5;   // sub / sra
      end
    end else if (ins[6:0] == 7'b0010011) begin
      if (f3 == 3'b001) begin
        legal = (f7 == 7'h00); ctl = 3'd7; b = 32'(ins[24:20]);
      end else if (f3 == 3'b101) begin
        legal = (f7 == 7'h00) || (f7 == 7'h20); ctl = (f7 == 7'h20) ? 3'd5 : 3'd6;
        b = 32'(ins[24:20]);
      end else begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        b = 32'($signed(ins[31:20]));
        case (f3)
          3'b000: ctl = 3'd0;
          3'b100: ctl = 3'd4;
          3'b110: ctl = 3'd3;
          default: ctl = 3'd2;
        endcase
      end
    end
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wr, input logic [31:0] wd);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_rd     = wr;
    bus.wb_data   = wd;
  endtask

  // One clock: sample in_ready, predict, advance model across the edge
  task automatic tick();
    logic [31:0] view [32];
    bit          bz [32];
    logic [4:0]  s1, s2, d;
    bit          legal, uses2, hz, acc;
    logic [31:0] b;
    logic [2:0]  ctl;
    #2;
    obs_ready = bus.in_ready;
    view = ref_regs;
    bz   = ref_busy;
    if (bus.wb_en && bus.wb_rd != 5'd0) view[bus.wb_rd] = bus.wb_data;
    if (bus.wb_en) bz[bus.wb_rd] = 0;
    s1 = bus.in_instr[19:15];
    s2 = bus.in_instr[24:20];
    d  = bus.in_instr[11:7];
    ref_decode(bus.in_instr, view[s2], legal, uses2, b, ctl);
    hz = 0;
`ifdef ALU_OPSTAGE_SCOREBOARD_EN
    hz = legal && (bz[s1] || (uses2 && bz[s2]) || bz[d]);
`endif
    m_ready = !rst && (!m_valid || bus.out_ready) && !hz;
    acc = bus.in_valid && m_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ref_regs[i] = (i == 0) ? 32'h0 : RST_VAL;
        ref_busy[i] = 0;
      end
      m_valid = 0; m_in1 = '0; m_in2 = '0; m_ctrl = '0; m_rd = '0; m_illegal = 0;
    end else begin
      ref_regs = view;
      ref_busy = bz;
      if (acc && legal && d != 5'd0) ref_busy[d] = 1;
      if (acc && legal) begin
        m_valid = 1; m_in1 = view[s1]; m_in2 = b; m_ctrl = ctl; m_rd = d;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
      m_illegal = acc && !legal;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 1, 5'd5, 32'hFFFF);
    tick();
    n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", obs_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    n_tests++; if (bus.out_in_1 !== 32'h0) begin n_fail++; $display("FAIL rst_in_1 got=%h want=0", bus.out_in_1); end
    n_tests++; if (bus.out_in_2 !== 32'h0) begin n_fail++; $display("FAIL rst_in_2 got=%h want=0", bus.out_in_2); end
    n_tests++; if (bus.out_ctrl !== 3'b000) begin n_fail++; $display("FAIL rst_ctrl got=%b want=000", bus.out_ctrl); end
    n_tests++; if (bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got=%0d want=0", bus.out_rd); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got=%b want=0", bus.illegal); end
    rst = 1'b0;
    drive(0, 32'h0, 1, 0, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_decode();
    drive(0, 32'h0, 1, 1, 5'd1, 32'd128); tick();
    drive(0, 32'h0, 1, 1, 5'd2, 32'd2);   tick();
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b want=1", bus.out_valid); end
    n_tests++; if (bus.out_in_1 !== 32'd128) begin n_fail++; $display("FAIL add_in_1 got=%h want=80", bus.out_in_1); end
    n_tests++; if (bus.out_in_2 !== 32'd2) begin n_fail++; $display("FAIL add_in_2 got=%h want=2", bus.out_in_2); end
    n_tests++; if (bus.out_ctrl !== 3'b000) begin n_fail++; $display("FAIL add_ctrl got=%b want=000", bus.out_ctrl); end
    n_tests++; if (bus.out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd got=%0d want=3", bus.out_rd); end
    drive(1, rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 1, 1, 5'd3, 32'h0); tick();
    n_tests++; if (bus.out_ctrl !== 3'b001) begin n_fail++; $display("FAIL sub_ctrl got=%b want=001", bus.out_ctrl); end
    n_tests++; if (bus.out_in_2 !== 32'd2) begin n_fail++; $display("FAIL sub_in_2 got=%h want=2", bus.out_in_2); end
    drive(1, itype(12'hFFF, 5'd1, 3'b111, 5'd4), 1, 1, 5'd4, 32'h0); tick();
    n_tests++; if (bus.out_in_2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL andi_in_2 got=%h want=ffffffff", bus.out_in_2); end
    n_tests++; if (bus.out_ctrl !== 3'b010) begin n_fail++; $display("FAIL andi_ctrl got=%b want=010", bus.out_ctrl); end
    drive(0, 32'h0, 1, 1, 5'd4, 32'h0); tick();
    drive(0, 32'h0, 1, 1, 5'd1, 32'h8000_000F); tick();
    drive(1, itype({7'h20, 5'd2}, 5'd1, 3'b101, 5'd5), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_in_1 !== 32'h8000_000F) begin n_fail++; $display("FAIL srai_in_1 got=%h want=8000000f", bus.out_in_1); end
    n_tests++; if (bus.out_in_2 !== 32'd2) begin n_fail++; $display("FAIL srai_in_2 got=%h want=2", bus.out_in_2); end
    n_tests++; if (bus.out_ctrl !== 3'b101) begin n_fail++; $display("FAIL srai_ctrl got=%b want=101", bus.out_ctrl); end
    drive(1, itype({7'h00, 5'd2}, 5'd1, 3'b001, 5'd5), 1, 1, 5'd5, 32'h0); tick();
    n_tests++; if (bus.out_ctrl !== 3'b111) begin n_fail++; $display("FAIL slli_ctrl got=%b want=111", bus.out_ctrl); end
    n_tests++; if (bus.out_in_2 !== 32'd2) begin n_fail++; $display("FAIL slli_in_2 got=%h want=2", bus.out_in_2); end
    drive(0, 32'h0, 1, 1, 5'd5, 32'h0); tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins_b;
    ins_b = rtype(7'h00, 5'd1, 5'd2, 3'b100, 5'd11);
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd10), 0, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_rd !== 5'd10) begin n_fail++; $display("FAIL bp_first_rd got=%0d want=10", bus.out_rd); end
    for (int i = 0; i < 3; i++) begin
      drive(1, ins_b, 0, 0, 5'd0, 32'h0); tick();
      n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got=%b want=0", i, obs_ready); end
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd10 || bus.out_in_1 !== 32'h8000_000F ||
                     bus.out_in_2 !== 32'd2 || bus.out_ctrl !== 3'b000) begin
        n_fail++; $display("FAIL bp_hold_bundle[%0d] got=v%b rd%0d %h %h %b want=v1 rd10 8000000f 00000002 000",
                           i, bus.out_valid, bus.out_rd, bus.out_in_1, bus.out_in_2, bus.out_ctrl);
      end
    end
    drive(1, ins_b, 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b want=1", obs_ready); end
    n_tests++; if (bus.out_rd !== 5'd11 || bus.out_ctrl !== 3'b100 || bus.out_in_1 !== 32'd2 ||
                   bus.out_in_2 !== 32'h8000_000F) begin
      n_fail++; $display("FAIL bp_second_bundle got=rd%0d %b %h %h want=rd11 100 00000002 8000000f",
                         bus.out_rd, bus.out_ctrl, bus.out_in_1, bus.out_in_2);
    end
    drive(0, 32'h0, 1, 1, 5'd10, 32'h0); tick();
    drive(0, 32'h0, 1, 1, 5'd11, 32'h0); tick();
  endtask

  task automatic test_illegal();
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd7), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL slt_illegal got=%b want=1", bus.illegal); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL slt_valid got=%b want=0", bus.out_valid); end
    drive(1, rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL bad_f7_ready got=%b want=1", obs_ready); end
    n_tests++; if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bad_f7 got=ill%b v%b want=ill1 v0", bus.illegal, bus.out_valid);
    end
    drive(1, rtype(7'h00, 5'd0, 5'd7, 3'b000, 5'd8), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL x7_not_busy got=%b want=1", obs_ready); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_end got=%b want=0", bus.illegal); end
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd8 || bus.out_in_1 !== RST_VAL) begin
      n_fail++; $display("FAIL after_illegal got=v%b rd%0d %h want=v1 rd8 %h", bus.out_valid, bus.out_rd, bus.out_in_1, RST_VAL);
    end
    drive(0, 32'h0, 1, 1, 5'd8, 32'h0); tick();
  endtask

  task automatic test_x0_forward();
    drive(0, 32'h0, 1, 1, 5'd0, 32'hDEAD_BEEF); tick();
    drive(1, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd9), 1, 1, 5'd0, 32'h1234_5678); tick();
    n_tests++; if (bus.out_in_1 !== 32'h0 || bus.out_in_2 !== 32'h0) begin
      n_fail++; $display("FAIL x0_read got=%h %h want=0 0", bus.out_in_1, bus.out_in_2);
    end
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), 1, 1, 5'd2, 32'h0000_1234); tick();
    n_tests++; if (bus.out_in_2 !== 32'h0000_1234 || bus.out_ctrl !== 3'b011) begin
      n_fail++; $display("FAIL wb_forward got=%h %b want=00001234 011", bus.out_in_2, bus.out_ctrl);
    end
    drive(0, 32'h0, 1, 1, 5'd9, 32'h0);  tick();
    drive(0, 32'h0, 1, 1, 5'd12, 32'h0); tick();
  endtask

`ifdef ALU_OPSTAGE_SCOREBOARD_EN
  task automatic test_scoreboard();
    logic [31:0] dep;
    dep = rtype(7'h00, 5'd1, 5'd3, 3'b000, 5'd6);
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL sb_producer_ready got=%b want=1", obs_ready); end
    for (int i = 0; i < 2; i++) begin
      drive(1, dep, 1, 0, 5'd0, 32'h0); tick();
      n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL sb_stall[%0d] got=%b want=0", i, obs_ready); end
    end
    drive(1, dep, 1, 1, 5'd3, 32'hAA); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL sb_release got=%b want=1", obs_ready); end
    n_tests++; if (bus.out_in_1 !== 32'hAA || bus.out_rd !== 5'd6) begin
      n_fail++; $display("FAIL sb_dep_bundle got=%h rd%0d want=000000aa rd6", bus.out_in_1, bus.out_rd);
    end
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd6), 1, 1, 5'd6, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL sb_waw_release got=%b want=1", obs_ready); end
    drive(1, rtype(7'h00, 5'd0, 5'd6, 3'b000, 5'd13), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL sb_set_wins got=%b want=0", obs_ready); end
    drive(0, 32'h0, 1, 1, 5'd6, 32'h0); tick();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'(20 + i)), 1, 0, 5'd0, 32'h0); tick();
      n_tests++; if (obs_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_rd !== 5'(20 + i)) begin
        n_fail++; $display("FAIL b2b[%0d] got=rdy%b v%b rd%0d want=rdy1 v1 rd%0d", i, obs_ready, bus.out_valid, bus.out_rd, 20 + i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 1, 5'(20 + i), 32'h0); tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] opc, f7;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       opc = 7'($urandom);
        1, 2, 3, 4: opc = 7'b0110011;
        default: opc = 7'b0010011;
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'($urandom);
        1:       f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      drive($urandom_range(0, 9) < 7,
            {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
             5'($urandom_range(0, 7)), opc},
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
      tick();
      n_tests++; if (obs_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b want=%b", n, obs_ready, m_ready); end
      n_tests++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, bus.out_valid, m_valid); end
      n_tests++; if (bus.illegal !== m_illegal) begin n_fail++; $display("FAIL rnd_illegal[%0d] got=%b want=%b", n, bus.illegal, m_illegal); end
      if (m_valid) begin
        n_tests++;
        if (bus.out_in_1 !== m_in1 || bus.out_in_2 !== m_in2 || bus.out_ctrl !== m_ctrl || bus.out_rd !== m_rd) begin
          n_fail++; $display("FAIL rnd_bundle[%0d] got=%h %h %b rd%0d want=%h %h %b rd%0d", n,
                             bus.out_in_1, bus.out_in_2, bus.out_ctrl, bus.out_rd, m_in1, m_in2, m_ctrl, m_rd);
        end
      end
    end
    // Retire anything left busy before moving on
    for (int r = 1; r < 8; r++) begin
      drive(0, 32'h0, 1, 1, 5'(r), $urandom); tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 0, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_loaded got=%b want=1", bus.out_valid); end
    rst = 1'b1;
    drive(0, 32'h0, 0, 1, 5'd1, 32'h0000_FFFF); tick();
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard got=%b want=0", bus.out_valid); end
    drive(1, rtype(7'h00, 5'd0, 5'd1, 3'b000, 5'd15), 1, 0, 5'd0, 32'h0); tick();
    n_tests++; if (bus.out_in_1 !== RST_VAL) begin n_fail++; $display("FAIL mid_no_wb got=%h want=%h", bus.out_in_1, RST_VAL); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin ref_regs[i] = '0; ref_busy[i] = 0; end
    m_valid = 0; m_in1 = '0; m_in2 = '0; m_ctrl = '0; m_rd = '0; m_illegal = 0; m_ready = 0;
    drive(0, 32'h0, 1, 0, 5'd0, 32'h0);
    #1;
    test_reset();
    test_decode();
    test_backpressure();
    test_illegal();
    test_x0_forward();
`ifdef ALU_OPSTAGE_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
